alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Multi-cycle controller that sequences the shared 16-bit Hack ALU to compute an unsigned shift-and-add multiply, giving the low 16 bits of a*b.
- Sits between the CPU-side request logic and the ALU instance owned by the parent. It drives the ALU operands and the six control bits each cycle, and captures the ALU result into internal registers.
- While the block is idle, ALU ownership returns to the parent through alu_own.

Parameters:
- EARLY_EXIT, 1: when 1, iteration stops once the remaining multiplier is zero. When 0, the block always runs 16 iterations.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- a  in  16  multiplicand; latched on an accepted start.
- b  in  16  multiplier; latched on an accepted start.
- busy  out  1  high from the cycle after an accepted start through the DONE cycle inclusive.
- done  out  1  one-cycle pulse in the DONE state.
- product  out  16  result, (a*b) mod 2^16. Held stable until the next accepted start.
- prod_zr  out  1  product==0, registered with product.
- alu_own  out  1  high while the sequencer drives the ALU (ADD and DBL states).
- alu_x  out  16  ALU x operand.
- alu_y  out  16  ALU y operand.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1 each  ALU control bits.
- alu_out  in  16  ALU result. Combinational return from the ALU in the same cycle.

Behaviour:
- Reset values:
  - state=IDLE.
  - busy=0, done=0, alu_own=0.
  - product=0, prod_zr=1.
  - acc, mcand, mplier and cnt all 0.
  - ALU outputs all 0.
- Reset mid-operation aborts: the block returns to IDLE next cycle, and no done pulse is generated.
- Registers: acc[15:0], mcand[15:0], mplier[15:0], cnt[3:0].
- IDLE:
  - ALU outputs are 0 and alu_own=0.
  - On start=1: acc<=0, mcand<=a, mplier<=b, cnt<=0, then go to ADD.
- ADD (alu_own=1):
  - If mplier[0]=1: alu_x=acc, alu_y=mcand, control {zx,nx,zy,ny,f,no}=000010 (x+y), and acc<=alu_out.
  - Else: alu_x=acc, alu_y=0, control=001100 (x AND all-ones, i.e. pass x), and acc is unchanged.
  - Next state is DBL.
- DBL (alu_own=1):
  - alu_x=mcand, alu_y=mcand, control=000010; mcand<=alu_out, so the multiplicand doubles through the ALU.
  - mplier<=mplier>>1 (logical shift), cnt<=cnt+1.
  - If cnt==15, or EARLY_EXIT=1 and (mplier>>1)==0: go to DONE. Otherwise go to ADD.
- DONE:
  - done=1 and busy=1; product<=acc and prod_zr<=(acc==0), both visible from the next cycle.
  - Next state is IDLE.
- Arithmetic: all additions wrap modulo 2^16 and no carry or overflow is reported. The ALU zr/ng outputs are not used.
- Latency with EARLY_EXIT=1:
  - Let k be the index of the highest set bit of b (k=0 when b is 0 or 1).
  - The block spends 2(k+1) cycles in ADD/DBL.
  - done is asserted 2(k+1)+1 cycles after the start-sample edge, and product is valid the cycle after done.
- Latency with EARLY_EXIT=0: done is asserted 33 cycles after the start-sample edge.
- start while busy=1 is ignored, with no queueing. start in the DONE cycle is also ignored.
- start held high continuously: a new operation is accepted on every return to IDLE.
- The ALU control outputs are a pure function of state and mplier[0], so they are glitch-stable within the cycle.

Test Plan:
- Reset, then hold reset for 2 cycles mid-operation -> busy=0, done never pulses, product=0, prod_zr=1, alu_own=0.
- a=7, b=6 (k=2) -> done exactly 7 cycles after the start sample; product=42, prod_zr=0. Sequence is ADD(pass), DBL, ADD(add), DBL, ADD(add), DBL.
- a=0x1234, b=0 -> done 3 cycles after start; product=0, prod_zr=1. Exactly one ADD (pass, control=001100) and one DBL.
- a=0xFFFF, b=0xFFFF with EARLY_EXIT=1 -> done 33 cycles after start; product=0x0001. Wrap is checked against a reference model.
- EARLY_EXIT=0, a=3, b=1 -> done 33 cycles after start; product=3. A start pulsed at cycle 10 is ignored, and the following start is accepted only after IDLE.
- Random sweep of 1000 (a,b) pairs -> product == (a*b)&0xFFFF. alu_own is high only in ADD/DBL, and busy is never high in IDLE.

Source files
------------

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-and-add multiply sequenced through the shared Hack ALU
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic        prod_zr,
    output logic        alu_own,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic        alu_zx,
    output logic        alu_nx,
    output logic        alu_zy,
    output logic        alu_ny,
    output logic        alu_f,
    output logic        alu_no,
    input  logic [15:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DBL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] acc;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic [3:0]  cnt;

    // DBL ends the run after 16 iterations, or as soon as no multiplier bits remain
    logic last_iter;
    assign last_iter = (cnt == 4'd15) || (EARLY_EXIT && (mplier[15:1] == 15'd0));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_ADD;
            S_ADD:  state_nxt = S_DBL;
            S_DBL:  state_nxt = last_iter ? S_DONE : S_ADD;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers: operands latched on start, ALU result captured in ADD/DBL
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= 16'd0;
            mcand   <= 16'd0;
            mplier  <= 16'd0;
            cnt     <= 4'd0;
            product <= 16'd0;
            prod_zr <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc    <= 16'd0;
                        mcand  <= a;
                        mplier <= b;
                        cnt    <= 4'd0;
                    end
                end
                S_ADD: begin
                    if (mplier[0]) acc <= alu_out;
                end
                S_DBL: begin
                    mcand  <= alu_out;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 4'd1;
                end
                S_DONE: begin
                    product <= acc;
                    prod_zr <= (acc == 16'd0);
                end
                default: ;
            endcase
        end
    end

    // Status and ALU drive depend only on state and mplier[0], so they are stable all cycle
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        alu_own = 1'b0;
        alu_x   = 16'd0;
        alu_y   = 16'd0;
        alu_zx  = 1'b0;
        alu_nx  = 1'b0;
        alu_zy  = 1'b0;
        alu_ny  = 1'b0;
        alu_f   = 1'b0;
        alu_no  = 1'b0;
        case (state)
            S_ADD: begin
                busy    = 1'b1;
                alu_own = 1'b1;
                alu_x   = acc;
                if (mplier[0]) begin
                    alu_y = mcand;
                    alu_f = 1'b1;
                end else begin
                    alu_zy = 1'b1;
                    alu_ny = 1'b1;
                end
            end
            S_DBL: begin
                busy    = 1'b1;
                alu_own = 1'b1;
                alu_x   = mcand;
                alu_y   = mcand;
                alu_f   = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
